bootram_bus_ctrl: RTL and testbench
===================================

Name: bootram_bus_ctrl

Overview:
- PicoRV32 native-bus slave that fronts the 8 KiB boot RAM.
- The boot RAM is built as four 2Kx8 single-port byte-lane macros: lane 0 holds bits 7:0, up to lane 3 holding bits 31:24.
- Splits each 32-bit bus access into per-lane chip-enable, write-enable, address and data.
- Waits out the registered RAM read latency, assembles the 32-bit read word and returns a single-cycle ready.
- Supports a write-lock input, so boot code can freeze the RAM after loading.

Parameters:
- ADDR_W, 11: word-address width per lane. The lane depth is 2^ADDR_W bytes.
- READ_WAIT, 1: clock edges between issuing a read and sampling lane dout. Valid range is 1..3.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- mem_s_valid  in  1  bus request, already address-decoded to this block.
- mem_s_ready  out  1  transfer-complete strobe.
- mem_s_addr  in  32  byte address. Bits [ADDR_W+1:2] are used; all other bits are ignored.
- mem_s_wdata  in  32  write data.
- mem_s_wstrb  in  4  byte write strobes. A value of 0 means read.
- mem_s_rdata  out  32  read data.
- wr_lock  in  1  when 1, writes are acknowledged but not performed.
- ram_ce  out  4  per-lane chip enable.
- ram_wre  out  4  per-lane write enable.
- ram_oce  out  1  output-register enable to all lanes.
- ram_reset  out  1  RAM output reset to all lanes.
- ram_ad  out  ADDR_W  shared lane address.
- ram_din  out  32  lane write data. Byte n goes to lane n.
- ram_dout  in  32  lane read data. Byte n comes from lane n.

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE.
  - mem_s_ready=0, mem_s_rdata=0.
  - ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0.
  - Wait counter=0.
  - ram_reset is the inverse of resetn. ram_oce is tied to 1.
- All RAM-side outputs are registered. ram_ce and ram_wre are active for exactly one cycle per access.
- IDLE:
  - Acts on mem_s_valid=1 and mem_s_ready=0.
  - Latches ram_ad=mem_s_addr[ADDR_W+1:2] and ram_din=mem_s_wdata.
  - If wstrb!=0: ram_ce=ram_wre=(wr_lock ? 4'b0000 : wstrb), then go to WACK.
  - If wstrb==0: ram_ce=4'b1111, ram_wre=0, load the counter with READ_WAIT, then go to RWAIT.
- WACK:
  - ram_ce=ram_wre=0 and mem_s_ready=1 for this one cycle.
  - Next state is IDLE.
  - Write-to-ready latency is 2 cycles from the cycle valid is first seen.
- RWAIT:
  - ram_ce=0. The counter decrements each cycle.
  - When the counter reaches 1, capture mem_s_rdata<=ram_dout and go to RACK.
- RACK:
  - mem_s_ready=1 for one cycle. mem_s_rdata is valid in this cycle and holds its value afterwards.
  - Next state is IDLE.
  - Read latency is READ_WAIT+2 cycles, i.e. 3 with the default.
- Back-to-back accesses:
  - The master drops valid in the cycle after ready.
  - Because IDLE follows every ACK, a valid that is still high in that IDLE cycle with new address/wstrb starts a new access.
  - Sustained throughput is therefore one access per 3 cycles for writes and READ_WAIT+3 cycles for reads.
- wr_lock:
  - Sampled only in IDLE at write issue.
  - A change during WACK has no effect on the current write.
  - A locked write still returns ready and leaves the RAM unmodified.
- Partial writes: only the lanes with a set strobe bit get ce/wre. The other lanes are not enabled, so their contents are preserved.
- Address wrap: the upper address bits are ignored, so 0x0000_2000 aliases 0x0000_0000.
- Valid dropped mid-transaction (protocol violation): the FSM still completes the access and pulses ready. The request is not aborted.
- resetn asserted mid-access:
  - Everything returns to IDLE immediately with ce/wre=0.
  - A write that has already been issued may have completed. A read in flight is discarded and ready is not pulsed.

Test Plan:
- Write then read: write 0xDEADBEEF to addr 0x10 with wstrb=4'hF, then read 0x10.
  - Write: ready 2 cycles after valid; ram_ce=4'hF and ram_wre=4'hF for one cycle with ram_ad=4.
  - Read: ready 3 cycles after valid; rdata=0xDEADBEEF.
- Byte write: first write 0x11223344 to 0x20, then write 0x000000AA to 0x20 with wstrb=4'b0001.
  - ram_ce=4'b0001 for the byte write.
  - Subsequent read returns 0x112233AA.
- Lock: wr_lock=1, write 0xFFFFFFFF to 0x20 with wstrb=4'hF.
  - ready pulses and ram_ce=0.
  - A read of 0x20 still returns 0x112233AA.
- Alias/wrap: write 0x55AA55AA to 0x1FFC, then read 0x3FFC.
  - ram_ad=2047 for both accesses; rdata=0x55AA55AA.
- Back-to-back: hold valid high across alternating read/write requests, 8 accesses in total.
  - Exactly one ready per access, never two consecutive ready cycles.
  - All read data matches a reference memory model.
- Reset mid-read: drop resetn in the RWAIT cycle.
  - mem_s_ready stays 0, mem_s_rdata=0 and state=IDLE immediately.
  - After release, a new read of 0x10 returns 0xDEADBEEF (RAM contents are kept across reset).

Source files
------------

// File: rtl/bootram_bus_ctrl.sv
// PicoRV32 native-bus slave in front of the 8 KiB boot RAM, which is built from four byte-lane macros.
// It splits each bus access into per-lane strobes, waits out the RAM read latency and returns a one-cycle ready.
module bootram_bus_ctrl #(
    parameter int ADDR_W    = 11,
    parameter int READ_WAIT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_s_valid,
    output logic              mem_s_ready,
    input  logic [31:0]       mem_s_addr,
    input  logic [31:0]       mem_s_wdata,
    input  logic [3:0]        mem_s_wstrb,
    output logic [31:0]       mem_s_rdata,
    input  logic              wr_lock,
    output logic [3:0]        ram_ce,
    output logic [3:0]        ram_wre,
    output logic              ram_oce,
    output logic              ram_reset,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WACK  = 2'd1,
        RWAIT = 2'd2,
        RACK  = 2'd3
    } state_t;

    localparam logic [1:0] READ_WAIT_C = 2'(READ_WAIT);

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [3:0]          ce_q, ce_d;
    logic [3:0]          wre_q, wre_d;
    logic [ADDR_W-1:0]   ad_q, ad_d;
    logic [31:0]         din_q, din_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                addr_unused_s;

    // Only the word-address bits select a location; the rest alias.
    assign addr_unused_s = ^{mem_s_addr[31:ADDR_W+2], mem_s_addr[1:0]};

    // Next-state and registered-output logic of the access sequencer.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        ce_d    = 4'b0000;
        wre_d   = 4'b0000;
        ad_d    = ad_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // ready_q still high means this valid belongs to the access just acknowledged.
                if (mem_s_valid && !ready_q) begin
                    ad_d  = mem_s_addr[ADDR_W+1:2];
                    din_d = mem_s_wdata;
                    if (mem_s_wstrb != 4'b0000) begin
                        if (wr_lock) begin
                            ce_d  = 4'b0000;
                            wre_d = 4'b0000;
                        end else begin
                            ce_d  = mem_s_wstrb;
                            wre_d = mem_s_wstrb;
                        end
                        state_d = WACK;
                    end else begin
                        ce_d    = 4'b1111;
                        cnt_d   = READ_WAIT_C;
                        state_d = RWAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WACK: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            RWAIT: begin
                if (cnt_q == 2'd1) begin
                    rdata_d = ram_dout;
                    cnt_d   = 2'd0;
                    state_d = RACK;
                end else begin
                    cnt_d   = cnt_q - 2'd1;
                end
            end
            RACK: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            rdata_q <= 32'h0000_0000;
            ce_q    <= 4'b0000;
            wre_q   <= 4'b0000;
            ad_q    <= '0;
            din_q   <= 32'h0000_0000;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            ce_q    <= ce_d;
            wre_q   <= wre_d;
            ad_q    <= ad_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_s_ready = ready_q;
    assign mem_s_rdata = rdata_q;
    assign ram_ce      = ce_q;
    assign ram_wre     = wre_q;
    assign ram_ad      = ad_q;
    assign ram_din     = din_q;
    assign ram_oce     = 1'b1;
    assign ram_reset   = ~resetn;

endmodule

// File: tb/tb_bootram_bus_ctrl.sv
// Directed bench for bootram_bus_ctrl: a byte-lane RAM model behind the DUT and hand-computed expectations.
module tb_bootram_bus_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_s_valid;
    logic        mem_s_ready;
    logic [31:0] mem_s_addr;
    logic [31:0] mem_s_wdata;
    logic [3:0]  mem_s_wstrb;
    logic [31:0] mem_s_rdata;
    logic        wr_lock;
    logic [3:0]  ram_ce;
    logic [3:0]  ram_wre;
    logic        ram_oce;
    logic        ram_reset;
    logic [10:0] ram_ad;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_cnt = 0;
    int dbl_ready = 0;
    logic ready_prev = 1'b0;

    logic [7:0]  lane_mem [4][2048];
    logic [31:0] ref_mem [2048];

    always #5 clk = ~clk;

    bootram_bus_ctrl #(.ADDR_W(11), .READ_WAIT(1)) dut (
        .clk(clk), .resetn(resetn),
        .mem_s_valid(mem_s_valid), .mem_s_ready(mem_s_ready),
        .mem_s_addr(mem_s_addr), .mem_s_wdata(mem_s_wdata),
        .mem_s_wstrb(mem_s_wstrb), .mem_s_rdata(mem_s_rdata),
        .wr_lock(wr_lock),
        .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_oce(ram_oce),
        .ram_reset(ram_reset), .ram_ad(ram_ad),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Lane macros: byte write on the clock edge when ce and wre are both set.
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (ram_ce[l] && ram_wre[l]) lane_mem[l][ram_ad] <= ram_din[8*l +: 8];
        end
    end

    // Lane read data presented from the registered lane address.
    always_comb begin
        ram_dout = 32'h0;
        for (int l = 0; l < 4; l++) ram_dout[8*l +: 8] = lane_mem[l][ram_ad];
    end

    // Ready pulse counting and back-to-back ready detection.
    always @(negedge clk) begin
        ready_prev <= mem_s_ready;
        if (mem_s_ready) ready_cnt <= ready_cnt + 1;
        if (mem_s_ready && ready_prev) dbl_ready <= dbl_ready + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic lock,
                              output logic [31:0] rdata, output int lat,
                              output logic [3:0] ce1, output logic [3:0] wre1,
                              output logic [10:0] ad1, output int ce_cyc);
        mem_s_addr  = addr;
        mem_s_wdata = wdata;
        mem_s_wstrb = strb;
        wr_lock     = lock;
        mem_s_valid = 1'b1;
        lat = 0; ce_cyc = 0; ce1 = 4'h0; wre1 = 4'h0; ad1 = 11'h0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (ram_ce != 4'h0) ce_cyc++;
            if (lat == 1) begin
                ce1 = ram_ce; wre1 = ram_wre; ad1 = ram_ad;
            end
        end while (!mem_s_ready && lat < 20);
        if (!mem_s_ready) check_eq("ready_timeout", {31'b0, mem_s_ready}, 32'd1);
        rdata = mem_s_rdata;
        mem_s_valid = 1'b0;
        mem_s_wstrb = 4'h0;
        wr_lock     = 1'b0;
        @(posedge clk); #1;
        if (ram_ce != 4'h0) ce_cyc++;
    endtask

    logic [31:0] b_addr [8] = '{32'h100, 32'h100, 32'h104, 32'h104, 32'h7F8, 32'h7F8, 32'h100, 32'h100};
    logic [31:0] b_wd   [8] = '{32'hA5A5A5A5, 32'h0, 32'h00CCDD00, 32'h0, 32'h12345678, 32'h0, 32'hEE000000, 32'h0};
    logic [3:0]  b_st   [8] = '{4'hF, 4'h0, 4'h6, 4'h0, 4'hF, 4'h0, 4'h8, 4'h0};
    logic [31:0] b_exp  [8] = '{32'h0, 32'hA5A5A5A5, 32'h0, 32'h00CCDD00, 32'h0, 32'h12345678, 32'h0, 32'hEEA5A5A5};

    initial begin
        logic [31:0] rd;
        logic [3:0]  ce1, wre1;
        logic [10:0] ad1;
        int lat, cc, r0, d0;

        for (int l = 0; l < 4; l++)
            for (int a = 0; a < 2048; a++) lane_mem[l][a] = 8'h00;
        for (int a = 0; a < 2048; a++) ref_mem[a] = 32'h0;

        resetn = 1'b0; mem_s_valid = 1'b0; mem_s_addr = 32'h0;
        mem_s_wdata = 32'h0; mem_s_wstrb = 4'h0; wr_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'b0, mem_s_ready}, 32'd0);
        check_eq("rst_rdata", mem_s_rdata, 32'h0);
        check_eq("rst_ce", {28'b0, ram_ce}, 32'h0);
        check_eq("rst_wre", {28'b0, ram_wre}, 32'h0);
        check_eq("rst_ad", {21'b0, ram_ad}, 32'h0);
        check_eq("rst_din", ram_din, 32'h0);
        check_eq("rst_oce", {31'b0, ram_oce}, 32'd1);
        check_eq("rst_ramreset", {31'b0, ram_reset}, 32'd1);
        resetn = 1'b1;
        #1;
        check_eq("ramreset_rel", {31'b0, ram_reset}, 32'd0);
        @(posedge clk); #1;

        // Write then read
        bus_access(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, lat, ce1, wre1, ad1, cc);
        check_eq("w1_lat", 32'(lat), 32'd2);
        check_eq("w1_ce", {28'b0, ce1}, 32'hF);
        check_eq("w1_wre", {28'b0, wre1}, 32'hF);
        check_eq("w1_ad", {21'b0, ad1}, 32'd4);
        check_eq("w1_ce_cycles", 32'(cc), 32'd1);
        check_eq("w1_din", ram_din, 32'hDEADBEEF);
        bus_access(32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ce1, wre1, ad1, cc);
        check_eq("r1_lat", 32'(lat), 32'd3);
        check_eq("r1_ce", {28'b0, ce1}, 32'hF);
        check_eq("r1_wre", {28'b0, wre1}, 32'h0);
        check_eq("r1_ce_cycles", 32'(cc), 32'd1);
        check_eq("r1_data", rd, 32'hDEADBEEF);
        check_eq("r1_data_hold", mem_s_rdata, 32'hDEADBEEF);

        // Byte write
        bus_access(32'h20, 32'h11223344, 4'hF, 1'b0, rd, lat, ce1, wre1, ad1, cc);
        bus_access(32'h20, 32'h000000AA, 4'h1, 1'b0, rd, lat, ce1, wre1, ad1, cc);
        check_eq("bw_ce", {28'b0, ce1}, 32'h1);
        check_eq("bw_wre", {28'b0, wre1}, 32'h1);
        bus_access(32'h20, 32'h0, 4'h0, 1'b0, rd, lat, ce1, wre1, ad1, cc);
        check_eq("bw_data", rd, 32'h112233AA);

        // Locked write
        bus_access(32'h20, 32'hFFFFFFFF, 4'hF, 1'b1, rd, lat, ce1, wre1, ad1, cc);
        check_eq("lock_lat", 32'(lat), 32'd2);
        check_eq("lock_ce", {28'b0, ce1}, 32'h0);
        check_eq("lock_ce_cycles", 32'(cc), 32'd0);
        bus_access(32'h20, 32'h0, 4'h0, 1'b0, rd, lat, ce1, wre1, ad1, cc);
        check_eq("lock_data", rd, 32'h112233AA);

        // Address alias
        bus_access(32'h1FFC, 32'h55AA55AA, 4'hF, 1'b0, rd, lat, ce1, wre1, ad1, cc);
        check_eq("alias_w_ad", {21'b0, ad1}, 32'd2047);
        bus_access(32'h3FFC, 32'h0, 4'h0, 1'b0, rd, lat, ce1, wre1, ad1, cc);
        check_eq("alias_r_ad", {21'b0, ad1}, 32'd2047);
        check_eq("alias_data", rd, 32'h55AA55AA);

        // Back-to-back with valid held high
        r0 = ready_cnt; d0 = dbl_ready;
        mem_s_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mem_s_addr  = b_addr[k];
            mem_s_wdata = b_wd[k];
            mem_s_wstrb = b_st[k];
            if (b_st[k] != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (b_st[k][b]) ref_mem[b_addr[k][12:2]][8*b +: 8] = b_wd[k][8*b +: 8];
            end
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!mem_s_ready && lat < 20);
            if (!mem_s_ready) check_eq("b2b_timeout", {31'b0, mem_s_ready}, 32'd1);
            check_eq("b2b_lat", 32'(lat), ((b_st[k] != 4'h0) ? 32'd2 : 32'd3) + ((k > 0) ? 32'd1 : 32'd0));
            if (b_st[k] == 4'h0) begin
                check_eq("b2b_ref", mem_s_rdata, ref_mem[b_addr[k][12:2]]);
                check_eq("b2b_data", mem_s_rdata, b_exp[k]);
            end
        end
        mem_s_valid = 1'b0;
        mem_s_wstrb = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("b2b_ready_count", 32'(ready_cnt - r0), 32'd8);
        check_eq("b2b_double_ready", 32'(dbl_ready - d0), 32'd0);

        // Reset while a read is waiting on the RAM
        mem_s_addr = 32'h10; mem_s_wstrb = 4'h0; mem_s_valid = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_ce_issue", {28'b0, ram_ce}, 32'hF);
        resetn = 1'b0;
        #1;
        check_eq("mid_ready", {31'b0, mem_s_ready}, 32'd0);
        check_eq("mid_rdata", mem_s_rdata, 32'h0);
        check_eq("mid_ce", {28'b0, ram_ce}, 32'h0);
        mem_s_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_ready_held", {31'b0, mem_s_ready}, 32'd0);
        resetn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("post_rst_ready", {31'b0, mem_s_ready}, 32'd0);
        end
        bus_access(32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ce1, wre1, ad1, cc);
        check_eq("post_rst_data", rd, 32'hDEADBEEF);
        check_eq("post_rst_lat", 32'(lat), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
